// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: the CPU controller and the loader/debug port
// share one memory. Requesters are served round-robin, and each access is
// stretched over WAIT extra wait-state cycles.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_IDLE | memory free; pick a requester (ties go to ~last) and latch it
//   S_BUSY | access in flight; the cycle with cnt==0 is the final cycle
//          | and strobes done to the owner
module mem_arbiter #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int WAIT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_done,
    output logic          cpu_stall,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic [DW-1:0] ld_rdata,
    output logic          ld_done,
    output logic          gnt_cpu,
    output logic          gnt_ld,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    // The wait-state counter is 4 bits, so WAIT is truncated to that width.
    localparam logic [3:0] LP_WAIT = 4'(WAIT);

    state_t        r_state, w_state_nxt;
    logic          r_owner, w_owner_nxt;
    logic          r_last,  w_last_nxt;
    logic [3:0]    r_cnt,   w_cnt_nxt;
    logic          r_we,    w_we_nxt;
    logic [AW-1:0] r_addr,  w_addr_nxt;
    logic [DW-1:0] r_wdata, w_wdata_nxt;
    logic          w_win;
    logic          w_busy;
    logic          w_final;

    // State register plus the fields latched at grant. last resets to the
    // loader so that the CPU wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    // Next-state logic: round-robin grant in IDLE, wait-state countdown in BUSY.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_win       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cpu_req || ld_req) begin
                    // A lone requester wins outright; on a tie the requester
                    // not served last time wins.
                    w_win       = (cpu_req && ld_req) ? ~r_last : ld_req;
                    w_owner_nxt = w_win;
                    w_last_nxt  = w_win;
                    w_cnt_nxt   = LP_WAIT;
                    w_we_nxt    = w_win ? ld_we    : cpu_we;
                    w_addr_nxt  = w_win ? ld_addr  : cpu_addr;
                    w_wdata_nxt = w_win ? ld_wdata : cpu_wdata;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_busy  = (r_state == S_BUSY);
    assign w_final = w_busy && (r_cnt == 4'd0);

    // Memory-side outputs are gated by BUSY so the bus reads zero whenever idle.
    assign mem_en    = w_busy;
    assign mem_we    = w_busy & r_we;
    assign mem_addr  = w_busy ? r_addr  : '0;
    assign mem_wdata = w_busy ? r_wdata : '0;

    assign gnt_cpu = w_busy & ~r_owner;
    assign gnt_ld  = w_busy &  r_owner;

    // Completion strobes and read data are combinational from the final cycle.
    assign cpu_done  = w_final & ~r_owner;
    assign ld_done   = w_final &  r_owner;
    assign cpu_rdata = cpu_done ? mem_rdata : '0;
    assign ld_rdata  = ld_done  ? mem_rdata : '0;

    // The controller's state register is enabled by ~cpu_stall.
    assign cpu_stall = cpu_req & ~cpu_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with WAIT=2 and one with WAIT=0.
// Expected accesses are queued when a request is raised and are checked
// against each done strobe.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, ld_req, ld_we;
    logic [31:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
    logic [31:0] cpu_rdata, ld_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_done, cpu_stall, ld_done, gnt_cpu, gnt_ld, mem_en, mem_we;

    logic        cpu_req0;
    logic [31:0] cpu_addr0;
    logic [31:0] cpu_rdata0, ld_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
    logic        cpu_done0, cpu_stall0, ld_done0, gnt_cpu0, gnt_ld0, mem_en0, mem_we0;

    typedef struct {
        logic        owner;
        logic        we;
        logic [31:0] addr;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mem [256];
    bit          mem_init = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32), .WAIT(2)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata), .ld_done(ld_done),
        .gnt_cpu(gnt_cpu), .gnt_ld(gnt_ld),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.AW(32), .DW(32), .WAIT(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req0), .cpu_we(1'b0), .cpu_addr(cpu_addr0), .cpu_wdata(32'h0),
        .cpu_rdata(cpu_rdata0), .cpu_done(cpu_done0), .cpu_stall(cpu_stall0),
        .ld_req(1'b0), .ld_we(1'b0), .ld_addr(32'h0), .ld_wdata(32'h0),
        .ld_rdata(ld_rdata0), .ld_done(ld_done0),
        .gnt_cpu(gnt_cpu0), .gnt_ld(gnt_ld0),
        .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .mem_rdata(mem_rdata0)
    );

    // Memory model: combinational read, write committed in the final BUSY cycle.
    assign mem_rdata  = mem[mem_addr[7:0]];
    assign mem_rdata0 = mem[mem_addr0[7:0]];

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] = 32'h0;
            mem[8'h40] = 32'hDEADBEEF;
            mem[8'h44] = 32'hCAFEF00D;
            mem_init = 1'b1;
        end else if (rst && mem_en && mem_we && (cpu_done || ld_done)) begin
            mem[mem_addr[7:0]] = mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done strobe of the WAIT=2 instance must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst && (cpu_done || ld_done)) begin
            chk("single_done", {31'h0, cpu_done & ld_done}, 32'h0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'h1, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("sb_owner", {31'h0, ld_done}, {31'h0, e.owner});
                chk("sb_addr", mem_addr, e.addr);
                chk("sb_we", {31'h0, mem_we}, {31'h0, e.we});
                if (!e.we) chk("sb_rdata", e.owner ? ld_rdata : cpu_rdata, e.rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic owner, input logic we, input logic [31:0] addr,
                        input logic [31:0] rdata);
        exp_t e;
        e.owner = owner; e.we = we; e.addr = addr; e.rdata = rdata;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        ld_req = 1'b0;  ld_we = 1'b0;  ld_addr = 32'h0;  ld_wdata = 32'h0;
        cpu_req0 = 1'b0; cpu_addr0 = 32'h0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        ld_req = 1'b0;  ld_we = 1'b0;  ld_addr = 32'h0;  ld_wdata = 32'h0;
        cpu_req0 = 1'b0; cpu_addr0 = 32'h0;

        // Reset state: everything zero, stall follows cpu_req.
        #12;
        chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
        chk("rst_gnt", {30'h0, gnt_cpu, gnt_ld}, 32'h0);
        chk("rst_done", {30'h0, cpu_done, ld_done}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        cpu_req = 1'b1;
        #1 chk("rst_stall_hi", {31'h0, cpu_stall}, 32'h1);
        cpu_req = 1'b0;
        #1 chk("rst_stall_lo", {31'h0, cpu_stall}, 32'h0);
        tick();
        rst = 1'b1;

        // WAIT=2 CPU read of 0x40.
        cpu_req = 1'b1; cpu_addr = 32'h40;
        push(1'b0, 1'b0, 32'h40, 32'hDEADBEEF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_stall", {31'h0, cpu_stall}, {31'h0, k < 3});
            chk("t1_mem_en", {31'h0, mem_en}, {31'h0, k >= 1});
            chk("t1_done", {31'h0, cpu_done}, {31'h0, k == 3});
            if (k == 3) chk("t1_rdata", cpu_rdata, 32'hDEADBEEF);
            else        chk("t1_rdata_zero", cpu_rdata, 32'h0);
            tick();
        end
        cpu_req = 1'b0;

        // Both requesting and held: grants alternate CPU, loader, CPU, loader.
        do_reset();
        cpu_req = 1'b1; cpu_addr = 32'h40;
        ld_req  = 1'b1; ld_addr  = 32'h44;
        push(1'b0, 1'b0, 32'h40, 32'hDEADBEEF);
        push(1'b1, 1'b0, 32'h44, 32'hCAFEF00D);
        push(1'b0, 1'b0, 32'h40, 32'hDEADBEEF);
        push(1'b1, 1'b0, 32'h44, 32'hCAFEF00D);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("t2_gnt_cpu", {31'h0, gnt_cpu}, {31'h0, (k % 4 != 0) && ((k / 4) % 2 == 0)});
            chk("t2_gnt_ld", {31'h0, gnt_ld}, {31'h0, (k % 4 != 0) && ((k / 4) % 2 == 1)});
            chk("t2_ld_done", {31'h0, ld_done}, {31'h0, (k % 4 == 3) && ((k / 4) % 2 == 1)});
            tick();
        end
        cpu_req = 1'b0; ld_req = 1'b0;

        // Loader write to 0x10 while a CPU read of 0x10 waits behind it.
        do_reset();
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h10; ld_wdata = 32'h12345678;
        push(1'b1, 1'b1, 32'h10, 32'h0);
        for (int k = 0; k < 8; k++) begin
            if (k == 1) begin
                cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
                push(1'b0, 1'b0, 32'h10, 32'h12345678);
            end
            if (k == 4) ld_req = 1'b0;
            @(negedge clk);
            if (k >= 1 && k <= 3) begin
                chk("t3_mem_we", {31'h0, mem_we}, 32'h1);
                chk("t3_mem_addr", mem_addr, 32'h10);
                chk("t3_mem_wdata", mem_wdata, 32'h12345678);
            end
            chk("t3_stall", {31'h0, cpu_stall}, {31'h0, k >= 1 && k < 7});
            chk("t3_cpu_done", {31'h0, cpu_done}, {31'h0, k == 7});
            tick();
        end
        cpu_req = 1'b0;

        // WAIT=0 instance: a single BUSY cycle coincident with done.
        do_reset();
        cpu_req0 = 1'b1; cpu_addr0 = 32'h40;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) cpu_req0 = 1'b0;
            @(negedge clk);
            chk("t4_mem_en", {31'h0, mem_en0}, {31'h0, k == 1});
            chk("t4_done", {31'h0, cpu_done0}, {31'h0, k == 1});
            chk("t4_stall", {31'h0, cpu_stall0}, {31'h0, k == 0});
            if (k == 1) chk("t4_rdata", cpu_rdata0, 32'hDEADBEEF);
            tick();
        end

        // Reset during the second BUSY cycle aborts the access.
        do_reset();
        cpu_req = 1'b1; cpu_addr = 32'h44;
        tick();
        tick();
        @(negedge clk);
        chk("t5_busy_before", {31'h0, mem_en}, 32'h1);
        #1 rst = 1'b0;
        #1;
        chk("t5_mem_en_abort", {31'h0, mem_en}, 32'h0);
        chk("t5_no_done", {31'h0, cpu_done}, 32'h0);
        chk("t5_gnt_abort", {31'h0, gnt_cpu}, 32'h0);
        chk("t5_stall_in_rst", {31'h0, cpu_stall}, 32'h1);
        tick();
        tick();
        rst = 1'b1;
        push(1'b0, 1'b0, 32'h44, 32'hCAFEF00D);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t5_mem_en", {31'h0, mem_en}, {31'h0, k >= 1});
            chk("t5_done", {31'h0, cpu_done}, {31'h0, k == 3});
            tick();
        end
        cpu_req = 1'b0;

        // CPU drops its request and changes address mid-access.
        cpu_req = 1'b1; cpu_addr = 32'h40;
        push(1'b0, 1'b0, 32'h40, 32'hDEADBEEF);
        for (int k = 0; k < 7; k++) begin
            if (k == 1) begin
                cpu_req = 1'b0; cpu_addr = 32'h80;
            end
            @(negedge clk);
            if (k >= 1 && k <= 3) chk("t6_mem_addr", mem_addr, 32'h40);
            chk("t6_done", {31'h0, cpu_done}, {31'h0, k == 3});
            chk("t6_mem_en", {31'h0, mem_en}, {31'h0, k >= 1 && k <= 3});
            tick();
        end

        chk("sb_drained", sb.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
